// File: rtl/base_input_pkg.sv
// Shared types for the input debounce/qualification stage.
// It holds the filter FSM state encoding, the window classification and a small classifier helper.
package base_input_pkg;

   // Filter FSM states. dout is high exactly in FILT_HI and FILT_FALL.
   typedef enum logic [1:0] {
      FILT_LO   = 2'd0,
      FILT_RISE = 2'd1,
      FILT_HI   = 2'd2,
      FILT_FALL = 2'd3
   } filt_state_t;

   // Per-cycle classification of the sampled-history window.
   typedef enum logic [1:0] {
      ONE   = 2'd0,
      ZERO  = 2'd1,
      MIXED = 2'd2
   } win_class_t;

   // Maps the window reductions to a class. When w=1, exactly one of the two
   // reductions is always set, so the result is never MIXED.
   function automatic win_class_t classify(input logic all_one, input logic all_zero);
      if (all_one) begin
         return ONE;
      end else if (all_zero) begin
         return ZERO;
      end
      return MIXED;
   endfunction

endpackage

// File: rtl/base_sat_cnt.sv
// Saturating up-counter with a synchronous clear.
// When clr and inc are both set in the same cycle, clr takes priority.
// The count holds at all-ones and never wraps.
module base_sat_cnt #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [0:width-1] q
);

   // Count register: clear first, then saturating increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && !(&q)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/base_input_filt.sv
// Debounce/qualification filter.
// It accepts a level change only after the whole sample window has agreed for hold+1 consecutive cycles.
// It produces a registered clean level plus one-cycle rise and fall pulses.
// An aborted qualification is a glitch event.
// Optional feature macro: BASE_INPUT_FILT_GLITCH_CNT_EN.
//   Defined: glitch events are counted in glitch_cnt, which saturates, and clr_cnt clears that count.
//   Undefined: glitch_cnt is tied to 0 and clr_cnt is ignored.
module base_input_filt
   import base_input_pkg::*;
#(
   parameter int w    = 2,
   parameter int hold = 4,
   parameter int cw   = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [0:w-1]  din,
   input  logic          clr_cnt,
   output logic          dout,
   output logic          rise,
   output logic          fall,
   output logic [0:cw-1] glitch_cnt
);

   // The hold counter needs at least one bit so that hold=1 still elaborates.
   localparam int hcw = (hold > 1) ? $clog2(hold) : 1;
   localparam logic [hcw-1:0] hc_last = hcw'(hold - 1);

   filt_state_t    state, state_nxt;
   logic [hcw-1:0] hc, hc_nxt;
   logic           dout_nxt, rise_nxt, fall_nxt;
   logic           glitch;
   win_class_t     win;

   assign win = classify(&din, ~|din);

   // Next-state, hold-count and output-pulse decode for the qualification FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
      state_nxt = state;
      hc_nxt    = hc;
      dout_nxt  = dout;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      glitch    = 1'b0;
      case (state)
         FILT_LO: begin
            if (win == ONE) begin
               state_nxt = FILT_RISE;
               hc_nxt    = '0;
            end
         end
         FILT_RISE: begin
            if (win == ONE) begin
               if (hc == hc_last) begin
                  state_nxt = FILT_HI;
                  dout_nxt  = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  hc_nxt = hc + 1'b1;
               end
            end else begin
               state_nxt = FILT_LO;
               glitch    = 1'b1;
            end
         end
         FILT_HI: begin
            if (win == ZERO) begin
               state_nxt = FILT_FALL;
               hc_nxt    = '0;
            end
         end
         FILT_FALL: begin
            if (win == ZERO) begin
               if (hc == hc_last) begin
                  state_nxt = FILT_LO;
                  dout_nxt  = 1'b0;
                  fall_nxt  = 1'b1;
               end else begin
                  hc_nxt = hc + 1'b1;
               end
            end else begin
               state_nxt = FILT_HI;
               glitch    = 1'b1;
            end
         end
         default: begin
            state_nxt = FILT_LO;
            dout_nxt  = 1'b0;
         end
      endcase
   end

   // State, hold counter and registered outputs.
   // Asynchronous reset returns the filter to a fully unqualified FILT_LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FILT_LO;
         hc    <= '0;
         dout  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking updates, so every flop samples pre-edge values regardless of statement order.
         state <= state_nxt;
         hc    <= hc_nxt;
         dout  <= dout_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
      end
   end

`ifdef BASE_INPUT_FILT_GLITCH_CNT_EN
   // Diagnostic glitch counter. A clear in the same cycle as a glitch wins.
   base_sat_cnt #(
      .width (cw)
   ) u_glitch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (glitch),
      .clr   (clr_cnt),
      .q     (glitch_cnt)
   );
`else
   // The counter is absent, so its inputs go nowhere.
   assign glitch_cnt = '0;
   logic unused_cnt_inputs;
   assign unused_cnt_inputs = &{1'b0, clr_cnt, glitch};
`endif

endmodule
